// File: rtl/serial_add_sub_pkg.sv
// serial_add_sub_pkg: shared FSM state type and digit-counter sizing helper.
package serial_add_sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_width(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: operand/result handshake bundle for serial_add_sub.
interface serial_add_sub_if #(parameter int WIDTH = 16);
  logic in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic ci, sub;
  logic out_valid, out_ready;
  logic [WIDTH-1:0] s;
  logic co, ovf;
  modport master (output in_valid, a, b, ci, sub, out_ready,
                  input in_ready, out_valid, s, co, ovf);
  modport slave (input in_valid, a, b, ci, sub, out_ready,
                 output in_ready, out_valid, s, co, ovf);
endinterface

// File: rtl/serial_add_sub_ripple_digit_adder.sv
// ripple_digit_adder: DIGIT-bit ripple-carry adder exposing the carry into its top bit.
module ripple_digit_adder #(parameter int DIGIT = 4) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);
  logic [DIGIT:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i] = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end
  assign cout = c[DIGIT];
  assign cmsb = c[DIGIT-1];
endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: digit-serial adder/subtractor, one DIGIT-bit slice per cycle, LSB first.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic clk,
  input logic rst_n,
  serial_add_sub_if.slave bus
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  if (DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad
    $error("serial_add_sub: WIDTH must be a positive multiple of DIGIT");
  end
  state_t state;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic carry, co_q, ovf_q;
  logic [CW-1:0] cnt;
  logic [DIGIT-1:0] sum;
  logic cout, cmsb;
  int base;
  assign base = int'(cnt) * DIGIT;
  ripple_digit_adder #(.DIGIT(DIGIT)) u_add (
    .x(a_q[base +: DIGIT]),
    .y(b_q[base +: DIGIT]),
    .cin(carry),
    .sum(sum),
    .cout(cout),
    .cmsb(cmsb)
  );
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.s = s_q;
  assign bus.co = co_q;
  assign bus.ovf = ovf_q;
  // Subtraction is A + ~B + ~borrow, so B and the carry-in are inverted at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      carry <= 1'b0;
      co_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_q <= bus.a;
          b_q <= bus.b ^ {WIDTH{bus.sub}};
          carry <= bus.ci ^ bus.sub;
          cnt <= '0;
          state <= RUN;
        end
        RUN: begin
          s_q[base +: DIGIT] <= sum;
          carry <= cout;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            co_q <= cout;
            ovf_q <= cout ^ cmsb;
            state <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter DIGIT, default 4, bits processed per cycle; WIDTH % DIGIT == 0, DIGIT >= 1 (elaboration error otherwise).
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 ci  input  1  carry-in (add) / borrow-in (sub).
REQ-010 sub  input  1  0 = A+B+ci, 1 = A-B-ci.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 s  output  WIDTH  sum/difference.
REQ-014 co  output  1  carry-out (add) / not-borrow (sub).
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 FSM states IDLE, RUN, DONE; in_ready = 1 exactly in IDLE; out_valid = 1 exactly in DONE.
REQ-017 IDLE: on in_valid & in_ready at an edge, capture a, b^{WIDTH{sub}}, initial carry = ci^sub, clear digit counter, go RUN.
REQ-018 RUN: each edge add digit k of captured A and B plus carry register through one DIGIT-bit ripple adder; write result digit k into s register; update carry; increment counter.
REQ-019 Digits processed LSB first; N = WIDTH/DIGIT cycles in RUN; after digit N-1 go DONE.
REQ-020 Latency: accept at edge k -> out_valid high after edge k+N; throughput one operation per N+2 cycles minimum.
REQ-021 co = final carry; ovf = carry into MSB XOR carry out of MSB, both registered at the last digit.
REQ-022 DONE: s, co, ovf held stable while out_valid & !out_ready (arbitrary back-pressure length).
REQ-023 DONE with out_ready at an edge -> IDLE; no same-cycle accept of new operands (in_ready is 0 in DONE).
REQ-024 Inputs a, b, ci, sub ignored outside the accepting edge; changes during RUN have no effect.
REQ-025 DIGIT == WIDTH: N = 1, single RUN cycle; counter width ceil(log2(N)) with minimum 1 bit.
REQ-026 s retains the last result in IDLE until overwritten by the next operation's digits.

Reset
REQ-027 rst_n low asynchronously forces IDLE, s = 0, co = 0, ovf = 0, carry = 0, counter = 0, out_valid = 0.
REQ-028 Reset mid-RUN or mid-DONE aborts the operation; no result emitted; in_ready = 1 on the first edge after release.
REQ-029 No operand capture while rst_n low.

Structure
REQ-030 Shared package holds the state enum (IDLE, RUN, DONE) and the function computing counter width from N.
REQ-031 One sub-module ripple_digit_adder (parameter DIGIT; inputs x, y, cin; outputs sum, cout, cmsb = carry into top bit), built from per-bit full-adder logic.
REQ-032 All state, operand, result and flag registers in serial_add_sub; no combinational path from in_valid to out_valid or out_ready to in_ready.

Verification (WIDTH=16, DIGIT=4)
REQ-033 a=0x1234, b=0x4321, ci=0, sub=0 -> s=0x5555, co=0, ovf=0, out_valid exactly 4 edges after accept.
REQ-034 a=0xFFFF, b=0x0001, ci=0, sub=0 -> s=0x0000, co=1, ovf=0; a=0x7FFF, b=0x0001 -> s=0x8000, co=0, ovf=1.
REQ-035 a=0x0005, b=0x0007, ci=0, sub=1 -> s=0xFFFE, co=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, co=1, ovf=1.
REQ-036 out_ready held low 5 cycles in DONE -> s/co/ovf stable, in_ready=0; out_ready high -> IDLE next edge, in_ready=1.
REQ-037 rst_n pulsed low during RUN (after 2 digits) -> out_valid never asserts, s=0, in_ready=1 after release; next op 0x0001+0x0001 -> s=0x0002.
REQ-038 Regression at WIDTH=8, DIGIT=8 and DIGIT=1: random operands vs reference arithmetic, latency 1 and 8.
